stepper_axis_ctrl: RTL and testbench
====================================

Name: stepper_axis_ctrl

Overview:
- Parametrised stepper-axis controller for the balance platform. Replaces the fixed step/dir logic in the datapath.
- Performs homing against the end_left switch and tracks absolute position in steps.
- Executes move-to-target commands with a programmable step half-period.
- Aborts safely on unexpected limit-switch hits and exposes state and position for HEX and debug use.

Parameters:
- POS_W, 16, width of position, target and limit values.
- HALF_W, 20, width of the step half-period counter.
- DEF_HALF, 25000, half-period in clocks used when half_period input is 0 (1 kHz step rate at 50 MHz).
- MAX_POS, 3200, maximum legal position; targets above this are clamped.
- SETTLE, 4, clocks dir must be stable before the first step rising edge.

Ports:
- clock, in, 1, system clock (50 MHz).
- reset_n, in, 1, asynchronous active-low reset.
- calibrate, in, 1, one-cycle pulse that starts homing.
- move_valid, in, 1, move request.
- move_ready, out, 1, high only in IDLE with homed=1; a move is accepted when move_valid and move_ready are both high.
- target, in, POS_W, absolute target position, sampled on accept.
- half_period, in, HALF_W, step half-period in clocks, sampled on accept or calibrate; 0 selects DEF_HALF.
- abort, in, 1, level; requests a stop at the next step-low boundary.
- end_left, in, 1, asynchronous left limit switch, active high.
- end_right, in, 1, asynchronous right limit switch, active high.
- step, out, 1, step pulse to the driver; one step per rising edge.
- dir, out, 1, direction; 1 = toward end_right (increment), 0 = toward end_left.
- current_pos, out, POS_W, absolute position.
- busy, out, 1, high in HOME, SETTLE and MOVE.
- homed, out, 1, high once a valid home reference exists.
- done, out, 1, one-cycle pulse when a move or homing completes normally.
- fault, out, 1, sticky; cleared only by calibrate or reset.
- db_estado, out, 3, encoded state.

Behaviour:
- Reset values (async, reset_n=0): state IDLE, step=0, dir=0, current_pos=0, busy=0, homed=0, done=0, fault=0, move_ready=0, counters=0.
- Synchroniser: end_left and end_right pass through a 2-flop synchroniser; all decisions use the synchronised values (2-cycle latency).
- State encoding: IDLE=000, HOME=001, SETTLE=010, MOVE=011, FAULT=100.
- Step generator: the half-period counter runs only in HOME and MOVE. step toggles when the counter reaches the latched half-period minus 1, then the counter clears.
- Position update: on each step rising edge, current_pos increments if dir=1 and decrements if dir=0.
- State is never left while step=1. Exits wait for the falling-edge toggle; the only exception is reset.
- IDLE + calibrate:
  - dir=0, fault cleared, homed=0, go to HOME. busy is high the next cycle.
  - calibrate is honoured in IDLE and FAULT only, and has priority over a simultaneous move_valid.
- HOME:
  - Step left until synchronised end_left=1, then finish the current pulse low.
  - Set current_pos=0, homed=1, pulse done, go to IDLE.
  - end_left already high on entry: zero steps issued; done fires 1 cycle after entry.
  - end_right=1 during HOME: go to FAULT.
- IDLE + move accept:
  - Latch tgt = min(target, MAX_POS).
  - If tgt == current_pos: no step, done pulses the next cycle, stay IDLE.
  - Otherwise set dir = (tgt > current_pos) and go to SETTLE.
- SETTLE: wait SETTLE clocks with step=0, then go to MOVE.
- MOVE:
  - Stop when current_pos == tgt after a rising edge; complete the low half, then pulse done and go to IDLE.
  - abort=1: stop at the next step-low boundary and go to IDLE with no done. Position stays valid.
  - Synchronised end_left=1 while dir=0: force current_pos=0, set fault, go to FAULT with homed kept at 1.
  - Synchronised end_right=1 while dir=1: set fault, clear homed, go to FAULT.
  - A limit switch opposite to the direction of travel is ignored.
- FAULT: step=0, busy=0, move_ready=0; leave only via calibrate (to HOME).
- Width: current_pos never wraps. A decrement at 0 is suppressed and increments saturate at MAX_POS; both are guaranteed by the stop rules.
- Mid-operation reset: immediate return to reset values, step forced low.

Decomposition:
- Shared package stepper_pkg:
  - state encoding constants (IDLE, HOME, SETTLE, MOVE, FAULT);
  - DIR_LEFT=0 and DIR_RIGHT=1 constants.
- One sub-module, step_pulse_gen:
  - contents: half-period counter, step toggle, rise-edge strobe and low-boundary strobe;
  - parameter: HALF_W.
- Synchroniser and FSM stay in the top of the block.

Test Plan:
- Reset, calibrate, end_left raised after 5 steps with half_period=4: exactly 5 rising step edges, then current_pos=0, homed=1, done pulse, db_estado=000.
- Homed, move target=10, half_period=2: dir=1 for SETTLE=4 clocks before the first edge, 10 rising edges, current_pos=10, done once, step=0 at exit. Then target=3: dir=0, 7 edges, current_pos=3.
- target=5000 with MAX_POS=3200: clamps and stops at 3200. Then target=3200: no steps, done the next cycle.
- Abort asserted after the 4th edge of a 0→20 move: stop with step low, current_pos=4, no done, move_ready=1.
- end_right asserted during a right move: fault=1, homed=0, db_estado=100, move_valid ignored. Then calibrate recovers to homed=1 with fault=0.
- Reset_n pulsed low mid-MOVE while step=1: step=0, current_pos=0, homed=0 immediately.

Source files
------------

// File: rtl/stepper_pkg.sv
// +------------------------------------------------------------------+
// | stepper_pkg : shared state encoding and direction constants       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package stepper_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_HOME   = 3'b001;
    localparam logic [2:0] ST_SETTLE = 3'b010;
    localparam logic [2:0] ST_MOVE   = 3'b011;
    localparam logic [2:0] ST_FAULT  = 3'b100;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// +------------------------------------------------------------------+
// | step_pulse_gen : half-period counter driving the step square wave |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module step_pulse_gen #(
    parameter int HALF_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_stop,
    input  logic [HALF_W-1:0] i_half,
    output logic              o_step,
    output logic              o_rise,
    output logic              o_fall
);

    localparam logic [HALF_W-1:0] c_one = HALF_W'(1);

    logic [HALF_W-1:0] r_cnt;
    logic              r_step;
    logic              w_tick;

    assign w_tick = i_en && (r_cnt == (i_half - c_one));
    assign o_rise = w_tick && !r_step;
    assign o_fall = w_tick && r_step;
    assign o_step = r_step;

    // A stop request overrides a coincident toggle so the state that is
    // being left can never emit a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else if (i_stop || !i_en) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_step <= ~r_step;
        end else begin
            r_cnt  <= r_cnt + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stepper_axis_ctrl.sv
// +------------------------------------------------------------------+
// | stepper_axis_ctrl : homing, absolute positioning and limit faults |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module stepper_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int POS_W    = 16,
    parameter int HALF_W   = 20,
    parameter int DEF_HALF = 25000,
    parameter int MAX_POS  = 3200,
    parameter int SETTLE   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              calibrate,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [POS_W-1:0]  target,
    input  logic [HALF_W-1:0] half_period,
    input  logic              abort,
    input  logic              end_left,
    input  logic              end_right,
    output logic              step,
    output logic              dir,
    output logic [POS_W-1:0]  current_pos,
    output logic              busy,
    output logic              homed,
    output logic              done,
    output logic              fault,
    output logic [2:0]        db_estado
);

    localparam int                c_sw          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_sw-1:0]   c_settle_last = c_sw'(SETTLE - 1);
    localparam logic [c_sw-1:0]   c_settle_one  = c_sw'(1);
    localparam logic [POS_W-1:0]  c_max_pos     = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0]  c_pos_one     = POS_W'(1);
    localparam logic [HALF_W-1:0] c_def_half    = HALF_W'(DEF_HALF);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_left_meta, r_left_sync;
    logic              r_right_meta, r_right_sync;
    logic [c_sw-1:0]   r_settle_cnt;
    logic [HALF_W-1:0] r_half;
    logic [POS_W-1:0]  r_tgt;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic              r_homed;
    logic              r_fault;
    logic              r_done;

    logic              w_step, w_rise, w_fall;
    logic              w_run, w_exit, w_low_ok, w_accept;
    logic              w_left_hit, w_right_hit;
    logic [POS_W-1:0]  w_tgt_clamped;
    logic [HALF_W-1:0] w_half_sel;

    assign w_tgt_clamped = (target > c_max_pos) ? c_max_pos : target;
    assign w_half_sel    = (half_period == '0) ? c_def_half : half_period;
    assign w_accept      = move_valid && move_ready;
    assign w_run         = (r_state == ST_HOME) || (r_state == ST_MOVE);
    assign w_low_ok      = !w_step || w_fall;
    assign w_exit        = w_run && (w_next != r_state);
    assign w_left_hit    = r_left_sync && (r_dir == DIR_LEFT);
    assign w_right_hit   = r_right_sync && (r_dir == DIR_RIGHT);

    assign step        = w_step;
    assign dir         = r_dir;
    assign current_pos = r_pos;
    assign homed       = r_homed;
    assign done        = r_done;
    assign fault       = r_fault;

    step_pulse_gen #(
        .HALF_W (HALF_W)
    ) u_step_gen (
        .clk    (clock),
        .rst_n  (reset_n),
        .i_en   (w_run),
        .i_stop (w_exit),
        .i_half (r_half),
        .o_step (w_step),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_left_meta  <= 1'b0;
            r_left_sync  <= 1'b0;
            r_right_meta <= 1'b0;
            r_right_sync <= 1'b0;
        end else begin
            r_left_meta  <= end_left;
            r_left_sync  <= r_left_meta;
            r_right_meta <= end_right;
            r_right_sync <= r_right_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every exit from a stepping state is gated by w_low_ok, so step is
    // always low when the state changes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (calibrate) begin
                    w_next = ST_HOME;
                end else if (w_accept && (w_tgt_clamped != r_pos)) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_HOME: begin
                if (w_low_ok) begin
                    if (r_right_sync) begin
                        w_next = ST_FAULT;
                    end else if (r_left_sync) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == c_settle_last) begin
                    w_next = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (w_low_ok) begin
                    if (w_left_hit || w_right_hit) begin
                        w_next = ST_FAULT;
                    end else if ((r_pos == r_tgt) || abort) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                if (calibrate) begin
                    w_next = ST_HOME;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        move_ready = (r_state == ST_IDLE) && r_homed;
        busy       = (r_state == ST_HOME) || (r_state == ST_SETTLE) || (r_state == ST_MOVE);
        db_estado  = r_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + c_settle_one;
        end else begin
            r_settle_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_half  <= '0;
            r_tgt   <= '0;
            r_pos   <= '0;
            r_dir   <= DIR_LEFT;
            r_homed <= 1'b0;
            r_fault <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FAULT: begin
                    if (calibrate) begin
                        r_dir   <= DIR_LEFT;
                        r_fault <= 1'b0;
                        r_homed <= 1'b0;
                        r_half  <= w_half_sel;
                    end else if (w_accept) begin
                        r_tgt  <= w_tgt_clamped;
                        r_half <= w_half_sel;
                        if (w_tgt_clamped == r_pos) begin
                            r_done <= 1'b1;
                        end else begin
                            r_dir <= (w_tgt_clamped > r_pos) ? DIR_RIGHT : DIR_LEFT;
                        end
                    end
                end
                ST_HOME, ST_MOVE: begin
                    if (w_exit) begin
                        if (w_next == ST_FAULT) begin
                            r_fault <= 1'b1;
                            if (r_state == ST_MOVE && w_left_hit) begin
                                r_pos <= '0;
                            end else begin
                                r_homed <= 1'b0;
                            end
                        end else if (r_state == ST_HOME) begin
                            r_pos   <= '0;
                            r_homed <= 1'b1;
                            r_done  <= 1'b1;
                        end else if (r_pos == r_tgt) begin
                            r_done <= 1'b1;
                        end
                    end else if (w_rise) begin
                        if (r_dir == DIR_RIGHT) begin
                            if (r_pos < c_max_pos) begin
                                r_pos <= r_pos + c_pos_one;
                            end
                        end else if (r_pos != '0) begin
                            r_pos <= r_pos - c_pos_one;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stepper_axis_ctrl.sv
// +------------------------------------------------------------------+
// | tb_stepper_axis_ctrl : scoreboard bench for stepper_axis_ctrl     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_stepper_axis_ctrl;

    localparam int POS_W   = 16;
    localparam int HALF_W  = 20;
    localparam int SETTLE  = 4;
    localparam int MAX_POS = 3200;

    typedef struct {
        int pos;
        int rises;
        int dones;
        int base_r;
        int base_d;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              calibrate;
    logic              move_valid;
    logic              move_ready;
    logic [POS_W-1:0]  target;
    logic [HALF_W-1:0] half_period;
    logic              abort;
    logic              end_left;
    logic              end_right;
    logic              step;
    logic              dir;
    logic [POS_W-1:0]  current_pos;
    logic              busy;
    logic              homed;
    logic              done;
    logic              fault;
    logic [2:0]        db_estado;

    int   n_total = 0;
    int   n_bad   = 0;
    int   rises   = 0;
    int   dones   = 0;
    logic prev_step = 1'b0;
    int   b;
    exp_t sb_q[$];

    stepper_axis_ctrl #(
        .POS_W    (POS_W),
        .HALF_W   (HALF_W),
        .DEF_HALF (25000),
        .MAX_POS  (MAX_POS),
        .SETTLE   (SETTLE)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .calibrate   (calibrate),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .target      (target),
        .half_period (half_period),
        .abort       (abort),
        .end_left    (end_left),
        .end_right   (end_right),
        .step        (step),
        .dir         (dir),
        .current_pos (current_pos),
        .busy        (busy),
        .homed       (homed),
        .done        (done),
        .fault       (fault),
        .db_estado   (db_estado)
    );

    always #10 clock = ~clock;

    // Counts step rising edges and done pulses as seen during each cycle.
    always @(posedge clock) begin
        prev_step <= step;
        if (step && !prev_step) rises <= rises + 1;
        if (done) dones <= dones + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_exp(input int pos, input int r, input int d);
        exp_t e;
        e.pos = pos; e.rises = r; e.dones = d; e.base_r = rises; e.base_d = dones;
        sb_q.push_back(e);
    endtask

    task automatic wait_rises(input string tag, input int base, input int n, input int lim);
        int t = 0;
        while ((rises - base) < n && t < lim) begin
            @(negedge clock);
            t++;
        end
        check_val({tag, "_rise_wait"}, rises - base, n);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int t = 0;
        while (busy && t < lim) begin
            @(negedge clock);
            t++;
        end
        check_val({tag, "_idle_wait"}, busy, 0);
    endtask

    task automatic finish_op(input string tag);
        exp_t e;
        wait_idle(tag, 20000);
        cyc(2);
        e = sb_q.pop_front();
        check_val({tag, "_pos"}, current_pos, e.pos);
        check_val({tag, "_rises"}, rises - e.base_r, e.rises);
        check_val({tag, "_dones"}, dones - e.base_d, e.dones);
        check_val({tag, "_step"}, step, 0);
    endtask

    task automatic move_cmd(input int tgt, input int half, input logic exp_dir, input bit chk_settle);
        int   c = 0;
        logic dir_ok = 1'b1;
        move_valid  = 1'b1;
        target      = POS_W'(tgt);
        half_period = HALF_W'(half);
        @(negedge clock);
        move_valid  = 1'b0;
        if (chk_settle) begin
            while (!step && c < 100) begin
                if (dir !== exp_dir) dir_ok = 1'b0;
                c++;
                @(negedge clock);
            end
            check_val("settle_dir", dir_ok, 1);
            check_val("settle_len", c >= SETTLE, 1);
            check_val("first_edge", step, 1);
        end
    endtask

    initial begin
        reset_n = 1'b0; calibrate = 1'b0; move_valid = 1'b0; target = '0;
        half_period = '0; abort = 1'b0; end_left = 1'b0; end_right = 1'b0;
        cyc(3);
        check_val("rst_step", step, 0);
        check_val("rst_pos", current_pos, 0);
        check_val("rst_homed", homed, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", move_ready, 0);
        check_val("rst_fault", fault, 0);
        check_val("rst_done", done, 0);
        check_val("rst_state", db_estado, 0);
        reset_n = 1'b1;
        cyc(2);

        // Homing: end_left raised after the 5th step
        push_exp(0, 5, 1);
        b = rises;
        calibrate = 1'b1; half_period = 4;
        @(negedge clock);
        calibrate = 1'b0;
        check_val("home_busy", busy, 1);
        wait_rises("home", b, 5, 500);
        end_left = 1'b1;
        finish_op("home");
        check_val("home_homed", homed, 1);
        check_val("home_state", db_estado, 0);
        check_val("home_ready", move_ready, 1);
        end_left = 1'b0;
        cyc(3);

        push_exp(10, 10, 1);
        move_cmd(10, 2, 1'b1, 1'b1);
        finish_op("mv10");
        check_val("mv10_ready", move_ready, 1);

        push_exp(3, 7, 1);
        move_cmd(3, 2, 1'b0, 1'b1);
        finish_op("mv3");

        push_exp(3200, 3197, 1);
        move_cmd(5000, 1, 1'b1, 1'b0);
        finish_op("clamp");

        push_exp(3200, 0, 1);
        move_cmd(3200, 1, 1'b1, 1'b0);
        check_val("atpos_done_next", done, 1);
        check_val("atpos_busy", busy, 0);
        finish_op("atpos");

        push_exp(0, 3200, 1);
        move_cmd(0, 1, 1'b0, 1'b0);
        finish_op("mv0");

        // Abort after the 4th edge of a 0 -> 20 move
        push_exp(4, 4, 0);
        b = rises;
        move_cmd(20, 2, 1'b1, 1'b0);
        wait_rises("abort", b, 4, 500);
        abort = 1'b1;
        finish_op("abort");
        abort = 1'b0;
        check_val("abort_ready", move_ready, 1);

        // end_right during a right move after the 3rd edge
        push_exp(7, 3, 0);
        b = rises;
        move_cmd(50, 2, 1'b1, 1'b0);
        wait_rises("flt", b, 3, 500);
        end_right = 1'b1;
        finish_op("flt");
        check_val("flt_fault", fault, 1);
        check_val("flt_homed", homed, 0);
        check_val("flt_state", db_estado, 3'b100);
        b = rises;
        move_valid = 1'b1; target = 100; half_period = 2;
        cyc(5);
        move_valid = 1'b0;
        check_val("flt_hold_state", db_estado, 3'b100);
        check_val("flt_hold_ready", move_ready, 0);
        check_val("flt_hold_rises", rises - b, 0);
        check_val("flt_hold_busy", busy, 0);

        // Recovery with end_left already active: zero-step homing
        end_right = 1'b0;
        end_left  = 1'b1;
        cyc(3);
        push_exp(0, 0, 1);
        calibrate = 1'b1; half_period = 3;
        @(negedge clock);
        calibrate = 1'b0;
        check_val("rehome_busy", busy, 1);
        check_val("rehome_fault_clr", fault, 0);
        @(negedge clock);
        check_val("rehome_done", done, 1);
        finish_op("rehome");
        check_val("rehome_homed", homed, 1);
        check_val("rehome_fault", fault, 0);
        end_left = 1'b0;
        cyc(3);

        // Asynchronous reset while step is high
        move_cmd(30, 4, 1'b1, 1'b0);
        begin
            int t = 0;
            while (!step && t < 200) begin
                @(negedge clock);
                t++;
            end
        end
        check_val("mrst_step_hi", step, 1);
        reset_n = 1'b0;
        #1;
        check_val("mrst_step", step, 0);
        check_val("mrst_pos", current_pos, 0);
        check_val("mrst_homed", homed, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_state", db_estado, 0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(2);
        check_val("mrst_ready", move_ready, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
